// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: shares one shift-register FIFO between two producers and
// one consumer. Writes are arbitrated round-robin onto the FIFO write port.
// Reads are sequenced into a 2-entry output buffer that presents a stream.
//
// Stream handshake (out_valid/out_ready): a word transfers on a rising clk
// edge when out_valid && out_ready are both high. While out_valid is high and
// out_ready is low, out_valid and out_data hold their values. out_valid never
// depends combinationally on out_ready.
module fifo_share_ctrl #(
    parameter int DW   = 8,
    parameter int OBUF = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic [DW-1:0] a_data,
    output logic          a_gnt,
    input  logic          b_req,
    input  logic [DW-1:0] b_data,
    output logic          b_gnt,
    output logic          write_req,
    output logic [DW-1:0] FIFO_write_data,
    input  logic          full_sig,
    output logic          read_req,
    input  logic [DW-1:0] FIFO_read_data,
    input  logic          empty_sig,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          last_src
);

    localparam logic [2:0] OBUF_L = 3'(OBUF);

    logic          rr_ptr_q, rr_ptr_d;
    logic          last_src_q, last_src_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] buf0_q, buf0_d;
    logic [DW-1:0] buf1_q, buf1_d;

    logic          cand_vld;
    logic          cand_sel;
    logic          grant;
    logic          pop;
    logic          push;
    logic [2:0]    net_cnt;

    // Pick the preferred port if it requests, else the other one; grant only
    // when the FIFO has room and the block is out of reset.
    always_comb begin
        cand_vld = 1'b0;
        cand_sel = rr_ptr_q;
        if (rr_ptr_q ? b_req : a_req) begin
            cand_vld = 1'b1;
            cand_sel = rr_ptr_q;
        end else if (rr_ptr_q ? a_req : b_req) begin
            cand_vld = 1'b1;
            cand_sel = ~rr_ptr_q;
        end
        grant = cand_vld && !full_sig && !rst;
    end

    assign write_req       = grant;
    assign a_gnt           = grant && !cand_sel;
    assign b_gnt           = grant && cand_sel;
    assign FIFO_write_data = grant ? (cand_sel ? b_data : a_data) : '0;

    // After a grant the other port becomes preferred; remember who won.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        last_src_d = last_src_q;
        if (grant) begin
            rr_ptr_d   = ~cand_sel;
            last_src_d = cand_sel;
        end
    end

    // Read issue: the buffer must have room for everything already held or
    // in flight, after this cycle's pop. pop implies occ_q >= 1, so no wrap.
    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q;
    assign net_cnt   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign read_req  = !empty_sig && !rst && (net_cnt < OBUF_L);
    assign inflight_d = read_req;

    // Output buffer: buf0 is the head, buf1 the second entry.
    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({push, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    buf0_d = FIFO_read_data;
                end else begin
                    buf1_d = FIFO_read_data;
                end
            end
            2'b01: begin
                occ_d  = occ_q - 2'd1;
                buf0_d = buf1_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = FIFO_read_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = FIFO_read_data;
                end
            end
            default: begin
            end
        endcase
    end

    assign out_data = buf0_q;
    assign last_src = last_src_q;

    // State registers; reset also drops any read return still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= 1'b0;
            last_src_q <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            last_src_q <= last_src_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule
